// File: rtl/alu_seq_if.sv
// Handshaked operand/result bundle for alu_seq.
// The master side presents operations and consumes results; the slave side is the ALU.
interface alu_seq_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [3:0]       Sel;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Out;
    logic             N;
    logic             Z;
    logic             V;

    modport master (
        output in_valid, A, B, Sel, out_ready,
        input  in_ready, out_valid, Out, N, Z, V
    );

    modport slave (
        input  in_valid, A, B, Sel, out_ready,
        output in_ready, out_valid, Out, N, Z, V
    );
endinterface

// File: rtl/alu_seq.sv
// Execute-stage ALU with valid/ready handshakes, registered result and N/Z/V flags,
// and an iterative shift-add multiply taking WIDTH cycles.
module alu_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_seq_if.slave   bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam int unsigned MSB   = WIDTH - 1;

    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_NEG  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0011;
    localparam logic [3:0] OP_PASS = 4'b0100;
    localparam logic [3:0] OP_MUL  = 4'b0101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [WIDTH-1:0] r_out;
    logic             r_n;
    logic             r_z;
    logic             r_v;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplr;
    logic [WIDTH-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;

    logic [WIDTH-1:0] w_alu_out;
    logic             w_alu_v;
    logic [WIDTH-1:0] w_acc_nxt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_mul_done;
    logic             w_in_ready;
    logic             w_accept;
    logic             w_load_mul;
    logic             w_wr_res;
    logic             w_from_mul;
    logic [WIDTH-1:0] w_wr_data;
    logic             w_wr_v;

    // Single-cycle opcodes; unknown opcodes fall through to zero with V clear.
    always_comb begin
        w_alu_out = '0;
        w_alu_v   = 1'b0;
        case (bus.Sel)
            OP_ADD: begin
                w_alu_out = bus.A + bus.B;
                w_alu_v   = (bus.A[MSB] == bus.B[MSB]) && (w_alu_out[MSB] != bus.A[MSB]);
            end
            OP_NEG:  w_alu_out = ~bus.B + WIDTH'(1);
            OP_SUB: begin
                w_alu_out = bus.B - bus.A;
                w_alu_v   = (bus.B[MSB] != bus.A[MSB]) && (w_alu_out[MSB] != bus.B[MSB]);
            end
            OP_PASS: w_alu_out = bus.A;
            default: ;
        endcase
    end

    // One shift-add step; the final step's add is folded into the written result.
    assign w_acc_nxt  = r_acc + (r_mplr[0] ? r_mcand : '0);
    assign w_cnt_inc  = r_cnt + CNT_W'(1);
    assign w_mul_done = (w_cnt_inc == CNT_W'(WIDTH));

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_accept    = 1'b0;
        w_load_mul  = 1'b0;
        w_wr_res    = 1'b0;
        w_from_mul  = 1'b0;
        case (r_state)
            IDLE: w_in_ready = 1'b1;
            MUL: begin
                if (w_mul_done) begin
                    w_wr_res    = 1'b1;
                    w_from_mul  = 1'b1;
                    w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                w_in_ready = bus.out_ready;
                if (bus.out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        // An accept from HOLD (result taken the same cycle) behaves exactly like one from IDLE.
        w_accept = bus.in_valid && w_in_ready;
        if (w_accept) begin
            if (bus.Sel == OP_MUL) begin
                w_load_mul  = 1'b1;
                w_state_nxt = MUL;
            end else begin
                w_wr_res    = 1'b1;
                w_state_nxt = HOLD;
            end
        end
    end

    assign w_wr_data = w_from_mul ? w_acc_nxt : w_alu_out;
    assign w_wr_v    = !w_from_mul && w_alu_v;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out   <= '0;
            r_n     <= 1'b0;
            r_z     <= 1'b0;
            r_v     <= 1'b0;
            r_mcand <= '0;
            r_mplr  <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
        end else begin
            if (w_wr_res) begin
                r_out <= w_wr_data;
                r_n   <= w_wr_data[MSB];
                r_z   <= (w_wr_data == '0);
                r_v   <= w_wr_v;
            end
            if (w_load_mul) begin
                r_mcand <= bus.A;
                r_mplr  <= bus.B;
                r_acc   <= '0;
                r_cnt   <= '0;
            end else if (r_state == MUL) begin
                r_mcand <= r_mcand << 1;
                r_mplr  <= r_mplr >> 1;
                r_acc   <= w_acc_nxt;
                r_cnt   <= w_cnt_inc;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = (r_state == HOLD);
    assign bus.Out       = r_out;
    assign bus.N         = r_n;
    assign bus.Z         = r_z;
    assign bus.V         = r_v;
endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed vectors, multiply/backpressure/reset sequences,
// randomized traffic against an arithmetic reference model, and a WIDTH=8 instance.
module tb_alu_seq;
    logic clk;
    logic rst_n;

    alu_seq_if #(.WIDTH(32)) b ();
    alu_seq_if #(.WIDTH(8))  b8 ();

    alu_seq #(.WIDTH(32)) dut  (.clk(clk), .rst_n(rst_n), .bus(b));
    alu_seq #(.WIDTH(8))  dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [3:0]  sel;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] out;
        logic        n;
        logic        z;
        logic        v;
    } vec_t;

    typedef struct {
        logic [31:0] o;
        logic        n;
        logic        z;
        logic        v;
    } res_t;

    vec_t vt[11];
    res_t q[$];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: signed overflow judged on true integer results, multiply as a full product.
    function automatic res_t model(input logic [31:0] a, input logic [31:0] bb, input logic [3:0] sel);
        res_t        r;
        longint      sa;
        longint      sb;
        longint      t;
        logic [63:0] p;
        sa  = longint'($signed(a));
        sb  = longint'($signed(bb));
        r.v = 1'b0;
        case (sel)
            4'd1: begin r.o = a + bb; t = sa + sb; r.v = (t > 64'sd2147483647) || (t < -64'sd2147483648); end
            4'd2: r.o = 32'd0 - bb;
            4'd3: begin r.o = bb - a; t = sb - sa; r.v = (t > 64'sd2147483647) || (t < -64'sd2147483648); end
            4'd4: r.o = a;
            4'd5: begin p = {32'd0, a} * {32'd0, bb}; r.o = p[31:0]; end
            default: r.o = 32'd0;
        endcase
        r.n = r.o[31];
        r.z = (r.o == 32'd0);
        return r;
    endfunction

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 5))
            0: return 32'h7FFF_FFFF;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'h0;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          cycles;
        logic        bad;
        logic        prev_hold;
        logic [34:0] prev_val;
        res_t        e;

        vt[0]  = '{4'b0001, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 1'b1, 1'b0, 1'b1};
        vt[1]  = '{4'b0011, 32'h5,         32'h5,         32'h0,         1'b0, 1'b1, 1'b0};
        vt[2]  = '{4'b0010, 32'h0,         32'h1,         32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0};
        vt[3]  = '{4'b0100, 32'h1234,      32'h9,         32'h1234,      1'b0, 1'b0, 1'b0};
        vt[4]  = '{4'b0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         1'b0, 1'b1, 1'b0};
        vt[5]  = '{4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         1'b0, 1'b1, 1'b0};
        vt[6]  = '{4'b0010, 32'h0,         32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, 1'b0};
        vt[7]  = '{4'b0011, 32'h1,         32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1};
        vt[8]  = '{4'b0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0};
        vt[9]  = '{4'b0011, 32'h3,         32'h1,         32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0};
        vt[10] = '{4'b0110, 32'h5,         32'h5,         32'h0,         1'b0, 1'b1, 1'b0};

        rst_n       = 1'b0;
        b.in_valid  = 1'b0;
        b.A         = '0;
        b.B         = '0;
        b.Sel       = '0;
        b.out_ready = 1'b1;
        b8.in_valid = 1'b0;
        b8.A        = '0;
        b8.B        = '0;
        b8.Sel      = '0;
        b8.out_ready = 1'b1;

        // Reset state
        #12;
        chk("rst_out_valid", b.out_valid, 0);
        chk("rst_out", b.Out, 0);
        chk("rst_nzv", {b.N, b.Z, b.V}, 0);
        chk("rst_in_ready", b.in_ready, 1);
        #8 rst_n = 1'b1;
        tick();

        // Directed vectors, back to back with out_ready high
        for (int i = 0; i < 11; i++) begin
            b.in_valid = 1'b1;
            b.A        = vt[i].a;
            b.B        = vt[i].b;
            b.Sel      = vt[i].sel;
            tick();
            chk($sformatf("vec%0d_valid", i), b.out_valid, 1);
            chk($sformatf("vec%0d_out", i), b.Out, vt[i].out);
            chk($sformatf("vec%0d_n", i), b.N, vt[i].n);
            chk($sformatf("vec%0d_z", i), b.Z, vt[i].z);
            chk($sformatf("vec%0d_v", i), b.V, vt[i].v);
        end
        b.in_valid = 1'b0;
        tick();
        chk("vec_idle_valid", b.out_valid, 0);

        // Multiply latency, in_ready low throughout, operation queued behind it
        b.in_valid = 1'b1;
        b.A        = 32'hFFFF_FFFD;
        b.B        = 32'h7;
        b.Sel      = 4'b0101;
        tick();
        b.A   = 32'hDEAD;
        b.Sel = 4'b0100;
        cycles = 0;
        bad    = 1'b0;
        while (!b.out_valid && cycles < 100) begin
            if (b.in_ready) bad = 1'b1;
            tick();
            cycles++;
        end
        chk("mul_latency", cycles, 32);
        chk("mul_in_ready_low", bad, 0);
        chk("mul_out", b.Out, 32'hFFFF_FFEB);
        chk("mul_nzv", {b.N, b.Z, b.V}, 3'b100);
        tick();
        chk("mul_next_valid", b.out_valid, 1);
        chk("mul_next_out", b.Out, 32'hDEAD);
        b.in_valid = 1'b0;
        tick();
        chk("mul_idle_valid", b.out_valid, 0);

        // Backpressure: held result stays put and nothing is accepted
        b.out_ready = 1'b0;
        b.in_valid  = 1'b1;
        b.A         = 32'h10;
        b.Sel       = 4'b0100;
        tick();
        chk("bp_first_out", b.Out, 32'h10);
        b.A   = 32'h1;
        b.B   = 32'h2;
        b.Sel = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp_hold%0d", i), {b.out_valid, b.in_ready, b.Out, b.N, b.Z, b.V},
                {1'b1, 1'b0, 32'h10, 3'b000});
            tick();
        end
        b.out_ready = 1'b1;
        #1;
        chk("bp_ready_comb", b.in_ready, 1);
        tick();
        chk("bp_release_out", {b.out_valid, b.Out}, {1'b1, 32'h3});
        b.in_valid = 1'b0;
        tick();

        // Randomized traffic with scoreboard and hold-stability checks
        prev_hold = 1'b0;
        prev_val  = '0;
        for (int c = 0; c < 1500; c++) begin
            b.out_ready = ($urandom_range(0, 3) != 0);
            b.in_valid  = ($urandom_range(0, 2) != 0);
            b.A         = rnd_operand();
            b.B         = rnd_operand();
            b.Sel       = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 5));
            #1;
            if (prev_hold) chk("rnd_stable", {b.out_valid, b.Out, b.N, b.Z, b.V}, {1'b1, prev_val});
            if (b.out_valid && b.out_ready) begin
                if (q.size() == 0) begin
                    chk("rnd_spurious_result", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("rnd_result", {b.Out, b.N, b.Z, b.V}, {e.o, e.n, e.z, e.v});
                end
            end
            prev_hold = b.out_valid && !b.out_ready;
            prev_val  = {b.Out, b.N, b.Z, b.V};
            if (b.in_valid && b.in_ready) q.push_back(model(b.A, b.B, b.Sel));
            tick();
        end
        b.in_valid  = 1'b0;
        b.out_ready = 1'b1;
        for (int c = 0; c < 40 && q.size() > 0; c++) begin
            if (b.out_valid) begin
                e = q.pop_front();
                chk("drain_result", {b.Out, b.N, b.Z, b.V}, {e.o, e.n, e.z, e.v});
            end
            tick();
        end
        chk("drain_empty", q.size(), 0);
        tick();

        // Reset in the middle of a multiply
        b.in_valid = 1'b1;
        b.A        = 32'h3;
        b.B        = 32'h5;
        b.Sel      = 4'b0101;
        tick();
        b.in_valid = 1'b0;
        repeat (9) tick();
        rst_n = 1'b0;
        #1;
        chk("mrst_out_valid", b.out_valid, 0);
        chk("mrst_out", b.Out, 0);
        chk("mrst_nzv", {b.N, b.Z, b.V}, 0);
        chk("mrst_in_ready", b.in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 1'b0;
        repeat (40) begin
            tick();
            if (b.out_valid) bad = 1'b1;
        end
        chk("mrst_no_partial", bad, 0);
        chk("mrst_in_ready_after", b.in_ready, 1);

        // WIDTH=8 instance: multiply latency and add overflow wrapping to zero
        b8.in_valid = 1'b1;
        b8.A        = 8'h0F;
        b8.B        = 8'h11;
        b8.Sel      = 4'b0101;
        tick();
        b8.in_valid = 1'b0;
        cycles = 0;
        while (!b8.out_valid && cycles < 50) begin
            tick();
            cycles++;
        end
        chk("w8_mul_latency", cycles, 8);
        chk("w8_mul_out", {b8.Out, b8.N, b8.Z, b8.V}, {8'hFF, 3'b100});
        b8.in_valid = 1'b1;
        b8.A        = 8'h80;
        b8.B        = 8'h80;
        b8.Sel      = 4'b0001;
        tick();
        chk("w8_add_out", {b8.out_valid, b8.Out, b8.N, b8.Z, b8.V}, {1'b1, 8'h00, 3'b011});
        b8.in_valid = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
